// File: rtl/ooo_fetch_decode_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO with first-word fall-through head,
// valid/ready handshakes on both sides and a single-cycle flush for mispredicts/ifence.
module ooo_fetch_decode_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_instr,
    input  logic [31:0]      enq_pc,
    input  logic             enq_prediction,
    input  logic             enq_fault,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_instr,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_pc4,
    output logic             deq_prediction,
    output logic             deq_fault,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      pc_mem_r    [DEPTH];
    logic             pred_mem_r  [DEPTH];
    logic             fault_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_s;
    logic             empty_s;
    logic             enq_fire_s;
    logic             deq_fire_s;

    // Status and handshake decode; full is judged on the registered count only, so a
    // same-cycle dequeue never opens a slot for the enqueue side.
    always_comb begin
        full_s     = (count_r == CNT_FULL);
        empty_s    = (count_r == '0);
        enq_fire_s = enq_valid && !full_s;
        deq_fire_s = deq_ready && !empty_s;
    end

    // Pointer and occupancy state; reset outranks flush, flush outranks both handshakes.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; deliberately not reset since pointers define validity.
    always_ff @(posedge CLK) begin
        if (enq_fire_s && !flush && !RST) begin
            instr_mem_r[wr_ptr_r] <= enq_instr;
            pc_mem_r[wr_ptr_r]    <= enq_pc;
            pred_mem_r[wr_ptr_r]  <= enq_prediction;
            fault_mem_r[wr_ptr_r] <= enq_fault;
        end
    end

    // Head entry falls through to the decode side.
    always_comb begin
        enq_ready      = !full_s;
        deq_valid      = !empty_s;
        deq_instr      = instr_mem_r[rd_ptr_r];
        deq_pc         = pc_mem_r[rd_ptr_r];
        deq_pc4        = pc_mem_r[rd_ptr_r] + 32'd4;
        deq_prediction = pred_mem_r[rd_ptr_r];
        deq_fault      = fault_mem_r[rd_ptr_r];
        count          = count_r;
    end

    ooo_fetch_decode_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk      (CLK),
        .rst      (RST),
        .count    (count_r),
        .enq_fire (enq_fire_s),
        .deq_fire (deq_fire_s),
        .full     (full_s),
        .empty    (empty_s)
    );

endmodule

// Simulation-only occupancy and handshake invariants for the queue.
module ooo_fetch_decode_queue_chk #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    input logic [PTR_W:0] count,
    input logic           enq_fire,
    input logic           deq_fire,
    input logic           full,
    input logic           empty
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_FULL);
    a_no_enq_full: assert property (@(posedge clk) disable iff (rst) !(enq_fire && full));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(deq_fire && empty));

endmodule

// File: tb/tb_ooo_fetch_decode_queue.sv
// Directed bench for the fetch/decode queue: queue-based reference model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_ooo_fetch_decode_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic        fault;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_instr = 32'h0;
    logic [31:0] enq_pc = 32'h0;
    logic        enq_prediction = 1'b0;
    logic        enq_fault = 1'b0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc4;
    logic        deq_prediction;
    logic        deq_fault;
    logic [2:0]  count;

    int     n_vec = 0;
    int     n_err = 0;
    bit     model_on = 1'b0;
    entry_t model_q[$];

    ooo_fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .CLK            (clk),
        .RST            (rst),
        .flush          (flush),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_instr      (enq_instr),
        .enq_pc         (enq_pc),
        .enq_prediction (enq_prediction),
        .enq_fault      (enq_fault),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_instr      (deq_instr),
        .deq_pc         (deq_pc),
        .deq_pc4        (deq_pc4),
        .deq_prediction (deq_prediction),
        .deq_fault      (deq_fault),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: an ordered list of held instructions.
    always @(posedge clk) begin
        bit do_enq;
        bit do_deq;
        entry_t e;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            do_enq = enq_valid && (model_q.size() < DEPTH);
            do_deq = deq_ready && (model_q.size() > 0);
            e = '{instr: enq_instr, pc: enq_pc, pred: enq_prediction, fault: enq_fault};
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back(e);
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("count", 32'(count), 32'(model_q.size()));
            chk("enq_ready", 32'(enq_ready), 32'(model_q.size() < DEPTH));
            chk("deq_valid", 32'(deq_valid), 32'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                chk("deq_instr", deq_instr, model_q[0].instr);
                chk("deq_pc", deq_pc, model_q[0].pc);
                chk("deq_pc4", deq_pc4, model_q[0].pc + 32'd4);
                chk("deq_prediction", 32'(deq_prediction), 32'(model_q[0].pred));
                chk("deq_fault", 32'(deq_fault), 32'(model_q[0].fault));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                        input logic pred, input logic fault);
        enq_valid = 1'b1; enq_instr = instr; enq_pc = pc;
        enq_prediction = pred; enq_fault = fault;
        cyc();
        enq_valid = 1'b0; enq_prediction = 1'b0; enq_fault = 1'b0;
    endtask

    task automatic pop();
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        model_on = 1'b1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_enq_ready", 32'(enq_ready), 32'd1);
        chk("reset_deq_valid", 32'(deq_valid), 32'd0);
        rst = 1'b0;

        // 1: three pushes with decode stalled, then drain in order
        push(32'hA000_0001, 32'h100, 1'b0, 1'b0);
        push(32'hB000_0002, 32'h104, 1'b1, 1'b0);
        push(32'hC000_0003, 32'h108, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_pc", deq_pc, 32'h100);
        chk("t1_pc4", deq_pc4, 32'h104);
        pop();
        chk("t1_pop_b", deq_pc, 32'h104);
        pop();
        chk("t1_pop_c", deq_instr, 32'hC000_0003);
        pop();
        chk("t1_empty", 32'(deq_valid), 32'd0);

        // 2: fill, pop once with enq held; slot opens only after the edge
        for (int i = 0; i < DEPTH; i++) push(32'h2000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        chk("t2_full_ready", 32'(enq_ready), 32'd0);
        enq_valid = 1'b1; enq_instr = 32'h2000_00EE; enq_pc = 32'h2EE;
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        chk("t2_count_after_pop", 32'(count), 32'd3);
        chk("t2_ready_reopen", 32'(enq_ready), 32'd1);
        cyc();
        enq_valid = 1'b0;
        chk("t2_count_refill", 32'(count), 32'd4);
        for (int i = 0; i < DEPTH; i++) pop();
        chk("t2_drained", 32'(deq_valid), 32'd0);

        // 3: steady state at count=2 with simultaneous enq/deq, pointers wrap
        push(32'h3000_0000, 32'h300, 1'b0, 1'b0);
        push(32'h3000_0001, 32'h304, 1'b1, 1'b0);
        for (int i = 2; i < 8; i++) begin
            enq_valid = 1'b1; enq_instr = 32'h3000_0000 + 32'(i); enq_pc = 32'h300 + 32'(4 * i);
            deq_ready = 1'b1;
            cyc();
            chk("t3_count_steady", 32'(count), 32'd2);
            chk("t3_head_order", deq_instr, 32'h3000_0000 + 32'(i - 1));
        end
        enq_valid = 1'b0; deq_ready = 1'b0;
        pop();
        pop();

        // 4: flush with both handshakes presented
        for (int i = 0; i < 3; i++) push(32'h4000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        enq_valid = 1'b1; enq_instr = 32'hDEAD_BEEF; enq_pc = 32'h4FC;
        deq_ready = 1'b1; flush = 1'b1;
        cyc();
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_deq_valid", 32'(deq_valid), 32'd0);
        push(32'h4000_00AA, 32'h480, 1'b0, 1'b0);
        chk("t4_no_stale", deq_instr, 32'h4000_00AA);
        pop();

        // 5: PC wrap and sideband flags
        push(32'h5000_0005, 32'hFFFF_FFFC, 1'b1, 1'b1);
        chk("t5_pc4_wrap", deq_pc4, 32'h0000_0000);
        chk("t5_fault", 32'(deq_fault), 32'd1);
        chk("t5_pred", 32'(deq_prediction), 32'd1);
        pop();

        // 6: reset while full with an enqueue presented
        for (int i = 0; i < DEPTH; i++) push(32'h6000_0000 + 32'(i), 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        enq_valid = 1'b1; enq_instr = 32'h6000_00FF; rst = 1'b1;
        cyc();
        rst = 1'b0; enq_valid = 1'b0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_enq_ready", 32'(enq_ready), 32'd1);
        chk("t6_deq_valid", 32'(deq_valid), 32'd0);
        cyc();
        chk("t6_discarded", 32'(count), 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
